reg_copy_engine: RTL and testbench

Initiator-side controller for the `register_file` block. On a `start` request it copies a contiguous, wrap-around range of registers from a source index to a destination index through register-file read port 1 and write port 3, one word per clock. Ranges may overlap, and the copy uses memmove semantics. The engine sits between a control master (start/busy/done handshake) and the register file's `addr1/rd1` and `addr3/wd3/we3` ports; read port 2 stays free for other users.

---
 rtl/reg_copy_engine.sv | 127 ++++++++++++
 tb/tb_reg_copy_engine.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/reg_copy_engine.sv
// reg_copy_engine
//
// Copies a contiguous, wrap-around range of registers inside a register file
// from index src to index dst, one word per clock. The copy has memmove
// semantics: when the destination range starts inside the source range
// (dst ahead of src), the beats run from the top of the range downwards so
// that no source word is overwritten before it is read.
//
// Ports
//   clk, reset       : single clock; synchronous active-high reset
//   start            : copy request, sampled only while idle
//   src, dst         : first source / destination register index
//   len              : number of words (0..2^N legal; larger is rejected)
//   busy             : high during the copy beats
//   done             : one-cycle completion pulse
//   err              : pulses with done when the request was rejected
//   addr1 / rd1      : register-file read port 1 (combinational read)
//   addr3 / wd3 / we3: register-file write port 3
module reg_copy_engine #(
    parameter int N = 2,
    parameter int M = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic [N-1:0] src,
    input  logic [N-1:0] dst,
    input  logic [N:0]   len,
    output logic         busy,
    output logic         done,
    output logic         err,
    output logic [N-1:0] addr1,
    input  logic [M-1:0] rd1,
    output logic [N-1:0] addr3,
    output logic [M-1:0] wd3,
    output logic         we3
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        COPY = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [N:0] FULL = (N+1)'(1) << N;
    localparam logic [N:0] ONE  = (N+1)'(1);

    state_t       state, state_nxt;
    logic [N-1:0] src_q, dst_q, idx_q;
    logic [N:0]   cnt_q;
    logic         back_q, err_q;

    // Request decode, only meaningful while idle.
    logic [N-1:0] diff;
    logic [N:0]   len_m1;
    logic         reject, noop, backward;

    assign diff     = dst - src;
    assign len_m1   = len - ONE;
    assign reject   = (len > FULL);
    assign noop     = (len == '0) || (diff == '0);
    // Destination starts inside the source range: walk the range top-down.
    assign backward = ({1'b0, diff} < len);

    // NOTE: clocked state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    // NOTE: every variable driven here gets a default first, so no path
    // through the case can leave it unassigned and infer a latch.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (start) state_nxt = (reject || noop) ? DONE : COPY;
            end
            COPY: begin
                if (cnt_q == ONE) state_nxt = DONE;
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            src_q  <= '0;
            dst_q  <= '0;
            idx_q  <= '0;
            cnt_q  <= '0;
            back_q <= 1'b0;
            err_q  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        src_q  <= src;
                        dst_q  <= dst;
                        cnt_q  <= len;
                        back_q <= backward;
                        err_q  <= reject;
                        idx_q  <= backward ? len_m1[N-1:0] : '0;
                    end
                end
                COPY: begin
                    cnt_q <= cnt_q - ONE;
                    idx_q <= back_q ? idx_q - 1'b1 : idx_q + 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign busy  = (state == COPY);
    assign done  = (state == DONE);
    assign err   = done && err_q;
    assign addr1 = src_q + idx_q;
    assign addr3 = dst_q + idx_q;
    assign wd3   = rd1;
    // Register 0 is hardwired zero, so beats aimed at it still count but
    // never write; nothing is written on an edge where reset is asserted.
    assign we3   = busy && (addr3 != '0) && !reset;

endmodule

// File: tb/tb_reg_copy_engine.sv
// Testbench for reg_copy_engine with a small register file (N=2, M=4).
// A behavioural model builds the expected per-cycle output stream for each
// request; one compare process checks the DUT against it every cycle.
module tb_reg_copy_engine;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b0;
    logic [1:0] src = '0;
    logic [1:0] dst = '0;
    logic [2:0] len = '0;
    logic       busy, done, err, we3;
    logic [1:0] addr1, addr3;
    logic [3:0] rd1, wd3;

    reg_copy_engine #(.N(2), .M(4)) dut (
        .clk(clk), .reset(reset), .start(start),
        .src(src), .dst(dst), .len(len),
        .busy(busy), .done(done), .err(err),
        .addr1(addr1), .rd1(rd1),
        .addr3(addr3), .wd3(wd3), .we3(we3)
    );

    always #5 clk = ~clk;

    // Register file: R0 reads zero, writes to R0 ignored. Write log for checks.
    logic [3:0] rf [4];
    logic       pre_en = 1'b0;
    logic [5:0] wlog [$];

    assign rd1 = (addr1 == 2'd0) ? 4'h0 : rf[addr1];

    always @(posedge clk) begin
        if (pre_en) begin
            rf[0] <= 4'h0; rf[1] <= 4'h5; rf[2] <= 4'hA; rf[3] <= 4'hF;
            wlog.delete();
        end else if (we3) begin
            wlog.push_back({addr3, wd3});
            if (addr3 != 2'd0) rf[addr3] <= wd3;
        end
    end

    // Scoreboard.
    int passed = 0;
    int total  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    typedef struct packed {
        logic       busy, done, err, we3;
        logic [1:0] addr1, addr3;
        logic [3:0] wd3;
    } exp_t;

    exp_t       q [$];
    logic [3:0] m [4];
    bit         cmp_en = 1'b0;
    int         done_seen = 0;
    int         err_seen  = 0;

    function automatic exp_t mk(input logic b, input logic dn, input logic er, input logic w,
                                input logic [1:0] a1, input logic [1:0] a3, input logic [3:0] wd);
        exp_t e;
        e.busy = b; e.done = dn; e.err = er; e.we3 = w;
        e.addr1 = a1; e.addr3 = a3; e.wd3 = wd;
        return e;
    endfunction

    // Model: one entry per cycle following the start edge. Data is read from
    // the model's register array as it evolves beat by beat.
    task automatic model_req(input int s, input int d, input int l);
        int diff, k, a1, a3;
        logic [3:0] v;
        diff = (d - s) & 3;
        if (l > 4) begin
            q.push_back(mk(0, 1, 1, 0, 2'd0, 2'd0, 4'h0));
        end else if (l == 0 || diff == 0) begin
            q.push_back(mk(0, 1, 0, 0, 2'd0, 2'd0, 4'h0));
        end else begin
            for (int j = 0; j < l; j++) begin
                k  = (diff >= l) ? j : l - 1 - j;
                a1 = (s + k) & 3;
                a3 = (d + k) & 3;
                v  = (a1 == 0) ? 4'h0 : m[a1];
                q.push_back(mk(1, 0, 0, a3 != 0, a1[1:0], a3[1:0], v));
                if (a3 != 0) m[a3] = v;
            end
            q.push_back(mk(0, 1, 0, 0, 2'd0, 2'd0, 4'h0));
        end
    endtask

    // Compare process: sampled 2 time units after each rising edge.
    always @(posedge clk) begin
        exp_t e;
        #2;
        if (cmp_en) begin
            if (q.size() > 0) begin
                e = q.pop_front();
                check("busy", busy, e.busy);
                check("done", done, e.done);
                check("err",  err,  e.err);
                check("we3",  we3,  e.we3);
                if (e.busy) begin
                    check("addr1", addr1, e.addr1);
                    check("addr3", addr3, e.addr3);
                    if (e.we3) check("wd3", wd3, e.wd3);
                end
            end else begin
                check("idle_busy", busy, 0);
                check("idle_done", done, 0);
                check("idle_err",  err,  0);
                check("idle_we3",  we3,  0);
            end
            if (done) done_seen++;
            if (err)  err_seen++;
        end
    end

    task automatic preload();
        @(negedge clk);
        pre_en = 1'b1;
        m[0] = 4'h0; m[1] = 4'h5; m[2] = 4'hA; m[3] = 4'hF;
        @(negedge clk);
        pre_en = 1'b0;
    endtask

    // Issue a request; with hold>0 start stays high (other operands) for
    // hold more cycles while the engine is busy.
    task automatic run(input int s, input int d, input int l, input int hold);
        @(negedge clk);
        start = 1'b1;
        src = s[1:0]; dst = d[1:0]; len = l[2:0];
        model_req(s, d, l);
        @(negedge clk);
        if (hold > 0) begin
            src = 2'd0; dst = 2'd1; len = 3'd1;
            repeat (hold) @(negedge clk);
        end
        start = 1'b0;
        for (int g = 0; g < 40 && q.size() > 0; g++) @(negedge clk);
        if (q.size() > 0) check("drain", q.size(), 0);
        @(negedge clk);
    endtask

    task automatic check_rf(input string tag);
        for (int i = 0; i < 4; i++)
            check($sformatf("%s_rf%0d", tag, i), rf[i], m[i]);
    endtask

    initial begin
        int d0, e0;

        // Reset state.
        repeat (3) @(posedge clk);
        #2;
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_err", err, 0);
        check("rst_we3", we3, 0);
        check("rst_addr1", addr1, 0);
        check("rst_addr3", addr3, 0);
        @(negedge clk);
        reset = 1'b0;
        cmp_en = 1'b1;

        // Forward copy.
        preload();
        run(1, 2, 1, 0);
        check_rf("fwd");
        check("fwd_R2", rf[2], 4'h5);
        check("fwd_nw", wlog.size(), 1);
        check("fwd_w0", wlog[0], {2'd2, 4'h5});

        // Overlapping, backward.
        preload();
        run(1, 2, 2, 0);
        check_rf("bwd");
        check("bwd_nw", wlog.size(), 2);
        check("bwd_w0", wlog[0], {2'd3, 4'hA});
        check("bwd_w1", wlog[1], {2'd2, 4'h5});
        check("bwd_R2", rf[2], 4'h5);
        check("bwd_R3", rf[3], 4'hA);

        // Wrap plus register 0.
        preload();
        run(2, 3, 2, 0);
        check_rf("wrap");
        check("wrap_nw", wlog.size(), 1);
        check("wrap_R1", rf[1], 4'h5);
        check("wrap_R2", rf[2], 4'hA);
        check("wrap_R3", rf[3], 4'hA);

        // Edge requests.
        preload();
        d0 = done_seen; e0 = err_seen;
        run(1, 2, 0, 0);
        check("len0_done", done_seen - d0, 1);
        check("len0_err", err_seen - e0, 0);
        run(1, 2, 5, 0);
        check("len5_done", done_seen - d0, 2);
        check("len5_err", err_seen - e0, 1);
        run(1, 1, 3, 0);
        check("same_done", done_seen - d0, 3);
        check_rf("edge");
        check("edge_nw", wlog.size(), 0);

        // Forward, two beats, source wraps through R0.
        preload();
        run(3, 1, 2, 0);
        check_rf("fwd2");
        check("fwd2_R1", rf[1], 4'hF);
        check("fwd2_R2", rf[2], 4'h0);

        // Full-size range.
        preload();
        run(0, 2, 4, 0);
        check_rf("full");

        // Start ignored while busy and in DONE.
        preload();
        d0 = done_seen;
        run(1, 2, 2, 3);
        check("ign_done", done_seen - d0, 1);
        check_rf("ign");

        // Reset in the 2nd COPY cycle of src=1,dst=2,len=3 (backward).
        preload();
        d0 = done_seen;
        @(negedge clk);
        start = 1'b1; src = 2'd1; dst = 2'd2; len = 3'd3;
        q.push_back(mk(1, 0, 0, 0, 2'd3, 2'd0, 4'h0));
        q.push_back(mk(1, 0, 0, 1, 2'd2, 2'd3, 4'hA));
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #2;
        check("rst_mid_busy", busy, 0);
        @(negedge clk);
        reset = 1'b0;
        repeat (4) @(negedge clk);
        check("rst_mid_done", done_seen - d0, 0);
        check("rst_mid_nw", wlog.size(), 0);
        check("rst_mid_R2", rf[2], 4'hA);
        check("rst_mid_R3", rf[3], 4'hF);
        check_rf("rst_mid");

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not end, got timeout expected finish");
        $fatal(1);
    end

endmodule
